// File: rtl/wormhole_switch_allocator.sv
// Switch allocator for an NPORTS-port wormhole router: one round-robin
// arbiter per output, optional head..tail locking, downstream-ready gating.
// Grants are combinational; crossbar select/valid are registered.
module wormhole_switch_allocator #(
   parameter  int NPORTS   = 5,
   parameter  int WORMHOLE = 1,
   localparam int PW       = $clog2(NPORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORTS-1:0]    req,
   input  logic [NPORTS*PW-1:0] req_dport,
   input  logic [NPORTS-1:0]    req_tail,
   input  logic [NPORTS-1:0]    out_ready,
   output logic [NPORTS-1:0]    grant,
   output logic [NPORTS*PW-1:0] xbar_sel,
   output logic [NPORTS-1:0]    xbar_valid,
   output logic                 err_dport
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

   logic [PW-1:0]       dport    [NPORTS];
   logic [PW-1:0]       rr_q     [NPORTS];
   logic [PW-1:0]       rr_d     [NPORTS];
   lock_e               state_q  [NPORTS];
   lock_e               state_d  [NPORTS];
   logic [PW-1:0]       owner_q  [NPORTS];
   logic [PW-1:0]       owner_d  [NPORTS];
   logic [PW-1:0]       win_idx  [NPORTS];
   logic [NPORTS-1:0]   win_vld;
   logic [NPORTS-1:0]   grant_c;
   logic [NPORTS-1:0]   xvalid_q;
   logic [NPORTS*PW-1:0] xsel_q;
   logic [NPORTS*PW-1:0] xsel_d;
   logic                err_q;
   logic                err_d;

   // Unpack destinations and flag any requester addressing a non-existent output.
   always_comb begin
      err_d = 1'b0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
         dport[i] = req_dport[i*PW +: PW];
         if (req[i] && (int'(dport[i]) >= NPORTS)) err_d = 1'b1;
      end
   end

   // Per-output arbitration: locked owner only, else round-robin scan from rr pointer.
   always_comb begin
      logic [PW-1:0] cand_idx;
      logic [PW-1:0] win;
      int unsigned   cand;
      cand     = 0;
      cand_idx = '0;
      win      = '0;
      grant_c  = '0;
      win_vld  = '0;
      xsel_d   = xsel_q;
      for (int unsigned o = 0; o < NPORTS; o++) begin
         win_idx[o] = '0;
         rr_d[o]    = rr_q[o];
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
      end
      for (int unsigned o = 0; o < NPORTS; o++) begin
         if (out_ready[o]) begin
            if (state_q[o] == LOCKED) begin
               if (req[owner_q[o]] && (dport[owner_q[o]] == PW'(o))) begin
                  win_vld[o] = 1'b1;
                  win_idx[o] = owner_q[o];
               end
            end else begin
               for (int unsigned k = 0; k < NPORTS; k++) begin
                  cand = k + rr_q[o];
                  if (cand >= NPORTS) cand = cand - NPORTS;
                  cand_idx = PW'(cand);
                  if (!win_vld[o] && req[cand_idx] && (dport[cand_idx] == PW'(o))) begin
                     win_vld[o] = 1'b1;
                     win_idx[o] = cand_idx;
                  end
               end
            end
         end
         if (win_vld[o]) begin
            win = win_idx[o];
            grant_c[win] = 1'b1;
            xsel_d[o*PW +: PW] = win;
            if (state_q[o] == LOCKED) begin
               if (req_tail[win]) state_d[o] = UNLOCKED;
            end else begin
               rr_d[o] = (win == PW'(NPORTS-1)) ? '0 : win + 1'b1;
               if ((WORMHOLE != 0) && !req_tail[win]) begin
                  state_d[o] = LOCKED;
                  owner_d[o] = win;
               end
            end
         end
      end
   end

   // Arbiter state and crossbar stage registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned o = 0; o < NPORTS; o++) begin
            rr_q[o]    <= '0;
            state_q[o] <= UNLOCKED;
            owner_q[o] <= '0;
         end
         xvalid_q <= '0;
         xsel_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         for (int unsigned o = 0; o < NPORTS; o++) begin
            rr_q[o]    <= rr_d[o];
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
         end
         xvalid_q <= win_vld;
         xsel_q   <= xsel_d;
         err_q    <= err_d;
      end
   end

   assign grant      = rst ? grant_c : '0;
   assign xbar_sel   = xsel_q;
   assign xbar_valid = xvalid_q;
   assign err_dport  = err_q;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Scoreboard bench for wormhole_switch_allocator (NPORTS=5, WORMHOLE=1).
module tb_wormhole_switch_allocator;

   localparam int N  = 5;
   localparam int PW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*PW-1:0] req_dport;
   logic [N-1:0]   req_tail;
   logic [N-1:0]   out_ready;
   logic [N-1:0]   grant;
   logic [N*PW-1:0] xbar_sel;
   logic [N-1:0]   xbar_valid;
   logic           err_dport;

   always #5 clk = ~clk;

   wormhole_switch_allocator #(.NPORTS(N), .WORMHOLE(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_dport  (req_dport),
      .req_tail   (req_tail),
      .out_ready  (out_ready),
      .grant      (grant),
      .xbar_sel   (xbar_sel),
      .xbar_valid (xbar_valid),
      .err_dport  (err_dport)
   );

   typedef struct {
      logic [N-1:0]    xv;
      logic [N*PW-1:0] xs;
      logic            err;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [PW-1:0] dp [N];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_dp(input int a, input int b, input int c, input int d, input int e);
      dp[0] = PW'(a); dp[1] = PW'(b); dp[2] = PW'(c); dp[3] = PW'(d); dp[4] = PW'(e);
   endtask

   // One cycle: drive inputs, check combinational grant, pop last cycle's
   // registered expectation, push this cycle's.
   task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] t, input logic [N-1:0] rdy,
                      input logic [N-1:0] eg, input logic eerr);
      exp_t e;
      exp_t p;
      @(posedge clk);
      #1;
      req       = r;
      req_tail  = t;
      out_ready = rdy;
      for (int i = 0; i < N; i++) req_dport[i*PW +: PW] = dp[i];
      @(negedge clk);
      chk("grant", 32'(grant), 32'(eg));
      if (sb.size() != 0) begin
         p = sb.pop_front();
         chk("xbar_valid", 32'(xbar_valid), 32'(p.xv));
         chk("err_dport", 32'(err_dport), 32'(p.err));
         for (int o = 0; o < N; o++)
            if (p.xv[o]) chk($sformatf("xbar_sel[%0d]", o), 32'(xbar_sel[o*PW +: PW]), 32'(p.xs[o*PW +: PW]));
      end else begin
         n_checks++;
         $display("FAIL scoreboard: got empty queue expected one entry");
      end
      e.xv  = '0;
      e.xs  = '0;
      e.err = eerr;
      for (int i = 0; i < N; i++) begin
         if (eg[i]) begin
            e.xv[dp[i]] = 1'b1;
            e.xs[dp[i]*PW +: PW] = PW'(i);
         end
      end
      sb.push_back(e);
   endtask

   initial begin
      exp_t e0;
      // Reset with every input requesting
      rst = 1'b0;
      set_dp(1, 1, 1, 1, 1);
      req = '1; req_tail = '1; out_ready = '1;
      for (int i = 0; i < N; i++) req_dport[i*PW +: PW] = dp[i];
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_grant", 32'(grant), 32'h0);
         chk("rst_xbar_valid", 32'(xbar_valid), 32'h0);
         chk("rst_xbar_sel", 32'(xbar_sel), 32'h0);
         chk("rst_err", 32'(err_dport), 32'h0);
      end
      req = '0;
      #2 rst = 1'b1;
      e0.xv = '0; e0.xs = '0; e0.err = 1'b0;
      sb.push_back(e0);

      // Arbitration resumes from pointer 0
      set_dp(0, 0, 0, 0, 0);
      cyc(5'b11111, 5'b11111, 5'b11111, 5'b00001, 1'b0);

      // Round-robin among inputs 0,2,4 on output 1
      set_dp(1, 0, 1, 0, 1);
      for (int k = 0; k < 2; k++) begin
         cyc(5'b10101, 5'b11111, 5'b11111, 5'b00001, 1'b0);
         cyc(5'b10101, 5'b11111, 5'b11111, 5'b00100, 1'b0);
         cyc(5'b10101, 5'b11111, 5'b11111, 5'b10000, 1'b0);
      end

      // Wormhole: move out2 pointer past input 1, then in3 sends a 4-flit packet
      set_dp(0, 0, 2, 0, 0);
      cyc(5'b00100, 5'b11111, 5'b11111, 5'b00100, 1'b0);
      set_dp(0, 2, 0, 2, 0);
      cyc(5'b01010, 5'b00010, 5'b11111, 5'b01000, 1'b0);
      cyc(5'b01010, 5'b00010, 5'b11111, 5'b01000, 1'b0);
      cyc(5'b01010, 5'b00010, 5'b11111, 5'b01000, 1'b0);
      cyc(5'b01010, 5'b01010, 5'b11111, 5'b01000, 1'b0);
      cyc(5'b00010, 5'b00010, 5'b11111, 5'b00010, 1'b0);

      // Backpressure mid-packet on output 2; lock must survive
      cyc(5'b01010, 5'b00010, 5'b11111, 5'b01000, 1'b0);
      for (int k = 0; k < 3; k++)
         cyc(5'b01010, 5'b00010, 5'b11011, 5'b00000, 1'b0);
      cyc(5'b01010, 5'b00010, 5'b11111, 5'b01000, 1'b0);
      cyc(5'b01010, 5'b01010, 5'b11111, 5'b01000, 1'b0);
      cyc(5'b00010, 5'b00010, 5'b11111, 5'b00010, 1'b0);

      // Parallel grants to distinct outputs
      set_dp(4, 3, 0, 0, 0);
      cyc(5'b00111, 5'b11111, 5'b11111, 5'b00111, 1'b0);

      // Out-of-range destination on input 0
      set_dp(7, 2, 0, 0, 0);
      cyc(5'b00011, 5'b11111, 5'b11111, 5'b00010, 1'b1);
      set_dp(0, 0, 0, 0, 0);
      cyc(5'b00000, 5'b11111, 5'b11111, 5'b00000, 1'b0);
      cyc(5'b00000, 5'b11111, 5'b11111, 5'b00000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
